// File: rtl/imem_loader.sv
// Runtime instruction-memory programmer: assembles a checksummed big-endian byte
// stream into a DEPTH-word store and holds the CPU until a verified program is present.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_instr,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   words_loaded,
    output logic              load_done,
    output logic              err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic [2:0]        r_state;
    logic [ADDR_W:0]   r_n;
    logic [ADDR_W:0]   r_words;
    logic [23:0]       r_asm;     // the three most recent payload bytes of the current word
    logic [7:0]        r_acc;
    logic [1:0]        r_bcnt;
    logic              r_load_done;
    logic [31:0]       r_mem [0:DEPTH-1];

    logic              w_accept;
    logic              w_hdr_bad;
    logic              w_word_done;
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_words_next;

    assign byte_ready   = (r_state == S_COUNT) || (r_state == S_DATA) || (r_state == S_CHECK);
    assign cpu_hold     = (r_state != S_RUN);
    assign err          = (r_state == S_ERROR);
    assign load_done    = r_load_done;
    assign words_loaded = r_words;

    assign w_accept     = byte_valid && byte_ready;
    assign w_hdr_bad    = (byte_data == 8'd0) || ({24'd0, byte_data} > 32'(DEPTH));
    assign w_word       = {r_asm, byte_data};
    assign w_words_next = r_words + (ADDR_W+1)'(1);
    // start wins over a byte arriving on the same edge, so the write is gated too
    assign w_word_done  = !start && w_accept && (r_state == S_DATA) && (r_bcnt == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_words     <= '0;
            r_asm       <= '0;
            r_acc       <= '0;
            r_bcnt      <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            if (start) begin
                r_state <= S_COUNT;
                r_words <= '0;
                r_asm   <= '0;
                r_acc   <= '0;
                r_bcnt  <= '0;
            end else if (w_accept) begin
                case (r_state)
                    S_COUNT: begin
                        if (w_hdr_bad) begin
                            r_state <= S_ERROR;
                        end else begin
                            r_n     <= (ADDR_W+1)'(byte_data);
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_asm  <= w_word[23:0];
                        r_acc  <= r_acc ^ byte_data;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_words <= w_words_next;
                            if (w_words_next == r_n) r_state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (byte_data == r_acc) begin
                            r_state     <= S_RUN;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the store is built from flops so reset can clear every word at once;
    // a RAM macro could not honour the asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_word_done) begin
            r_mem[r_words[ADDR_W-1:0]] <= w_word;
        end
    end

    always_comb begin
        fetch_instr = NOP;
        if ((32'(fetch_addr) < 32'(DEPTH)) &&
            !((r_state == S_RUN) && ({1'b0, fetch_addr} >= r_n)))
            fetch_instr = r_mem[fetch_addr];
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

    localparam int DEPTH = 32;
    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [4:0]  fetch_addr;
    logic [31:0] fetch_instr;
    logic        cpu_hold;
    logic [5:0]  words_loaded;
    logic        load_done;
    logic        err;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .fetch_addr   (fetch_addr),
        .fetch_instr  (fetch_instr),
        .cpu_hold     (cpu_hold),
        .words_loaded (words_loaded),
        .load_done    (load_done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Reference model: memory image, last verified word count and whether a program is live.
    logic [31:0] ref_mem [DEPTH];
    int          ref_n;
    bit          ref_run;
    logic [7:0]  tx_q [$];
    int          n_vec;
    int          n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_fetch(input int a);
        if (ref_run && a >= ref_n) return NOP;
        return ref_mem[a];
    endfunction

    task automatic sweep_fetch();
        for (int a = 0; a < DEPTH; a++) begin
            fetch_addr = a[4:0];
            #1;
            check("fetch", fetch_instr, exp_fetch(a));
        end
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ready", 32'(byte_ready), 1);
        check("start_hold", 32'(cpu_hold), 1);
        check("start_words", 32'(words_loaded), 0);
        check("start_err", 32'(err), 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            byte_data = 8'($urandom);
            @(negedge clk);
        end
        check("byte_ready", 32'(byte_ready), 1);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic run_session(input bit do_start, input int max_gap);
        logic [7:0]  hdr;
        logic [7:0]  acc;
        logic [7:0]  b;
        logic [7:0]  chk;
        logic [31:0] word;
        int          n;
        bit          good;
        if (do_start) pulse_start();
        ref_run = 1'b0;
        hdr = tx_q[0];
        send_byte(hdr, max_gap);
        if (hdr == 0 || hdr > DEPTH) begin
            check("hdr_err", 32'(err), 1);
            check("hdr_hold", 32'(cpu_hold), 1);
            check("hdr_ready", 32'(byte_ready), 0);
            check("hdr_done", 32'(load_done), 0);
            sweep_fetch();
            return;
        end
        n   = int'(hdr);
        acc = 8'h00;
        for (int w = 0; w < n; w++) begin
            word = '0;
            for (int k = 0; k < 4; k++) begin
                b    = tx_q[1 + 4*w + k];
                word = {word[23:0], b};
                acc  = acc ^ b;
                send_byte(b, max_gap);
            end
            ref_mem[w] = word;
            check("words", 32'(words_loaded), w + 1);
            fetch_addr = w[4:0];
            #1;
            check("wr_fetch", fetch_instr, word);
        end
        chk  = tx_q[1 + 4*n];
        good = (chk == acc);
        send_byte(chk, max_gap);
        check("done", 32'(load_done), 32'(good));
        check("err", 32'(err), 32'(!good));
        check("hold", 32'(cpu_hold), 32'(!good));
        check("ready_end", 32'(byte_ready), 0);
        check("words_end", 32'(words_loaded), n);
        @(negedge clk);
        check("done_pulse", 32'(load_done), 0);
        ref_run = good;
        ref_n   = n;
        sweep_fetch();
    endtask

    task automatic build_random();
        int         kind;
        int         n;
        logic [7:0] acc;
        logic [7:0] b;
        kind = int'($urandom_range(5, 0));
        tx_q.delete();
        if (kind == 0) begin
            tx_q.push_back(($urandom % 2 == 0) ? 8'h00 : 8'($urandom_range(255, DEPTH + 1)));
            return;
        end
        n = int'($urandom_range(DEPTH, 1));
        tx_q.push_back(8'(n));
        acc = 8'h00;
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom);
            tx_q.push_back(b);
            acc = acc ^ b;
        end
        if (kind == 1) acc = acc ^ 8'($urandom_range(255, 1));
        tx_q.push_back(acc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w0;
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_n      = 0;
        ref_run    = 1'b0;
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        fetch_addr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_hold", 32'(cpu_hold), 1);
        check("rst_ready", 32'(byte_ready), 0);
        check("rst_err", 32'(err), 0);
        check("rst_words", 32'(words_loaded), 0);
        check("rst_done", 32'(load_done), 0);
        sweep_fetch();

        // Directed good load, back-to-back
        tx_q = '{8'h02, 8'hB8, 8'h80, 8'h33, 8'hE3, 8'hCB, 8'h05, 8'h00, 8'hEA, 8'hCC};
        run_session(1'b1, 0);
        fetch_addr = 5'd2;
        #1;
        check("nop_addr2", fetch_instr, 32'hD503201F);
        @(negedge clk);

        // Bad checksum, then recovery
        tx_q[9] = 8'hCD;
        run_session(1'b1, 0);
        tx_q[9] = 8'hCC;
        run_session(1'b1, 0);

        // Bad headers
        tx_q = '{8'h00};
        run_session(1'b1, 0);
        tx_q = '{8'h21};
        run_session(1'b1, 0);

        // Stalled good stream
        tx_q = '{8'h02, 8'hB8, 8'h80, 8'h33, 8'hE3, 8'hCB, 8'h05, 8'h00, 8'hEA, 8'hCC};
        run_session(1'b1, 5);

        // Abort after 5 payload bytes; start collides with a valid byte that must be dropped
        pulse_start();
        send_byte(8'h03, 0);
        w0 = 32'h1122_3344;
        for (int k = 0; k < 4; k++) send_byte(8'(w0 >> (24 - 8*k)), 0);
        send_byte(8'h55, 0);
        ref_mem[0] = w0;
        ref_run    = 1'b0;
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h02;
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        check("abort_words", 32'(words_loaded), 0);
        check("abort_ready", 32'(byte_ready), 1);
        check("abort_hold", 32'(cpu_hold), 1);
        run_session(1'b0, 2);

        // Asynchronous reset mid-DATA
        pulse_start();
        send_byte(8'h04, 0);
        for (int k = 0; k < 6; k++) send_byte(8'($urandom), 0);
        #2;
        reset = 1'b0;
        #1;
        check("mrst_hold", 32'(cpu_hold), 1);
        check("mrst_ready", 32'(byte_ready), 0);
        check("mrst_err", 32'(err), 0);
        check("mrst_words", 32'(words_loaded), 0);
        check("mrst_done", 32'(load_done), 0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_run = 1'b0;
        sweep_fetch();
        reset = 1'b1;
        @(negedge clk);
        check("mrst_rel_hold", 32'(cpu_hold), 1);

        // Randomized sessions
        for (int s = 0; s < 15; s++) begin
            build_random();
            run_session(1'b1, int'($urandom_range(3, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Runtime instruction-memory programmer for the pipelined CPU. It receives a program as a byte stream over a valid/ready handshake (UART receiver or switch/key front end) and assembles big-endian 32-bit instruction words into a DEPTH-entry store. It checks a trailing XOR checksum and serves combinational instruction fetches to the CPU. It holds the CPU stalled until a complete, verified program is present, replacing the hard-wired instruction constant at top level.

## Interface
- DEPTH, 32: number of 32-bit instruction words stored.
- ADDR_W, 5: word-index width; must satisfy 2^ADDR_W >= DEPTH.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values immediately.
- start  in  1  single-cycle pulse that begins (or restarts) a load session.
- byte_valid  in  1  byte_data holds a byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle; decoded from state only and independent of byte_valid.
- fetch_addr  in  ADDR_W  CPU word index (PC >> 2).
- fetch_instr  out  32  instruction at fetch_addr; combinational read.
- cpu_hold  out  1  1 = CPU must stall or stay in reset.
- words_loaded  out  ADDR_W+1  count of words committed in the current session.
- load_done  out  1  1-cycle pulse when a program is verified.
- err  out  1  sticky error flag.

## Operation
- Stream format: header byte N (word count), then 4N payload bytes MSB-first per word, then one checksum byte equal to the XOR of all 4N payload bytes.
- A byte is accepted on a rising edge where byte_valid && byte_ready.
- States:
  - IDLE: byte_ready=0, cpu_hold=1. start -> COUNT.
  - COUNT: byte_ready=1. On an accepted byte: if N==0 or N>DEPTH -> ERROR; otherwise latch N -> DATA.
  - DATA: byte_ready=1.
    - Each accepted byte shifts into a 32-bit assembly register (new byte enters the LSB; the first byte ends in [31:24]) and is XORed into an 8-bit checksum accumulator.
    - A 2-bit byte counter wraps 3->0. On the 4th byte the completed word is written to mem[words_loaded] on the same edge, and words_loaded increments.
    - When words_loaded reaches N -> CHECK.
  - CHECK: byte_ready=1. On an accepted byte: if it equals the accumulator -> RUN and pulse load_done; otherwise -> ERROR.
  - RUN: cpu_hold=0, byte_ready=0. start -> COUNT.
  - ERROR: err=1, cpu_hold=1, byte_ready=0. Only start or reset leaves this state; start clears err and goes to COUNT.
- On start, in any state:
  - clears words_loaded, the byte counter, the accumulator and err;
  - goes to COUNT.
  - start has priority over a simultaneous byte accept; that byte is dropped.
- Memory contents are not cleared by start. Words beyond the new N are masked on read (see below).
- fetch_instr:
  - In RUN with fetch_addr >= N, returns NOP 32'hD503201F.
  - Otherwise returns mem[fetch_addr]; fetch_addr >= DEPTH returns the NOP.
- A failed session leaves partially written memory. This is harmless because cpu_hold stays 1.

## Timing
- Reset values: state IDLE, cpu_hold=1, byte_ready=0, err=0, load_done=0, words_loaded=0, N=0, accumulator=0, all mem words=0.
- Word write: the word is visible on fetch_instr in the cycle after the edge that accepts its 4th byte.
- Checksum byte accepted at edge k: in cycle k+1, load_done=1, cpu_hold=0 and byte_ready=0. load_done returns to 0 at k+2.
- start sampled at edge k: from cycle k+1, cpu_hold=1 and byte_ready=1.
- Errors: err rises in the cycle after the offending header or checksum byte.
- Stalls: byte_valid may drop for any number of cycles between bytes; state and counters hold.
- Reset asserted mid-session: immediate return to reset values, including memory.
- Max program length: 4*DEPTH+2 accepted bytes.

## Test plan
- Reset: drive reset=0, then release -> cpu_hold=1, byte_ready=0, err=0, words_loaded=0, fetch_instr=0 at every address.
- Good load, back-to-back bytes: start; bytes 02, B8 80 33 E3, CB 05 00 EA, CC -> one-cycle load_done, cpu_hold=0, words_loaded=2. fetch_addr 0 -> B88033E3, 1 -> CB0500EA, 2 -> D503201F.
- Bad checksum: same stream ending CD -> err=1, cpu_hold=1, byte_ready=0, no load_done. Then start plus the good stream -> err=0 and RUN.
- Bad header: header 00 -> ERROR. Separately, header 21 (33 > DEPTH) -> ERROR. In both cases no memory write occurs.
- Stalls and abort:
  - good stream with random 0-5 idle cycles between bytes -> same result as the back-to-back case;
  - start after 5 payload bytes -> words_loaded=0, state COUNT, and a following full stream loads correctly.
- Async reset mid-DATA: reset=0 between edges -> outputs reach reset values before the next edge; memory reads 0.
